// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder
//
// Matrix keypad scanner and decoder. It drives one-hot column strobes and
// samples the row lines once per column dwell. Each column sample is folded
// into a per-frame accumulator. The frame result is debounced across whole
// frames, and the block emits registered press and release events carrying a
// linear key code (row*COLS + col).
//
// Ports:
//   CLK       in   1     system clock, rising edge
//   RST       in   1     synchronous active-high reset
//   keyRows   in   ROWS  raw row lines, active-high, asynchronous to CLK
//   keyCols   out  COLS  one-hot active-high column strobe
//   Key       out  KW    last accepted key code
//   KeyValid  out  1     one-cycle pulse: new key accepted
//   KeyRel    out  1     one-cycle pulse: accepted key released
//   KeyDown   out  1     level: a key is currently held (accepted)
//   Multi     out  1     level: most recent frame saw two or more contacts
//
// The accepted-state FSM (stable_kind_q: NONE or KEY) is split into three
// processes: a register process, a next-state combinational process, and an
// output combinational process that drives the ports from the registers.
module keypad_scan_decoder #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  localparam int KW      = $clog2(ROWS*COLS)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [ROWS-1:0] keyRows,
  output logic [COLS-1:0] keyCols,
  output logic [KW-1:0]   Key,
  output logic            KeyValid,
  output logic            KeyRel,
  output logic            KeyDown,
  output logic            Multi
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(COLS);
  localparam int NW = $clog2(DEBOUNCE+1);

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_KEY  = 2'd1,
    RES_INV  = 2'd2
  } res_kind_e;

  logic [ROWS-1:0] rows_meta_q, rows_sync_q;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   col_q, col_d;
  logic [COLS-1:0] cols_q, cols_d;
  logic [1:0]      acc_cnt_q, acc_cnt_d;
  logic [KW-1:0]   acc_code_q, acc_code_d;
  res_kind_e       cand_kind_q, cand_kind_d;
  logic [KW-1:0]   cand_code_q, cand_code_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  res_kind_e       stable_kind_q, stable_kind_d;
  logic [KW-1:0]   key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic            key_rel_q, key_rel_d;
  logic            key_down_q, key_down_d;
  logic            multi_q, multi_d;

  // Contacts seen in the current column: count saturates at 2, and the code
  // belongs to the lowest-indexed row that is set.
  logic [1:0]    col_hits;
  logic [KW-1:0] col_code;
  logic [2:0]    sum_cnt;
  logic [1:0]    merged_cnt;
  logic [KW-1:0] merged_code;
  res_kind_e     res_kind;
  logic          sample, frame_end, same_as_cand;

  always_comb begin
    col_hits = 2'd0;
    col_code = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rows_sync_q[r]) begin
        if (col_hits == 2'd0) col_code = KW'(r*COLS + int'(col_q));
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
    sum_cnt     = {1'b0, acc_cnt_q} + {1'b0, col_hits};
    merged_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    // Earlier columns take priority for the first-contact code.
    merged_code = (acc_cnt_q == 2'd0) ? col_code : acc_code_q;
    case (merged_cnt)
      2'd0:    res_kind = RES_NONE;
      2'd1:    res_kind = RES_KEY;
      default: res_kind = RES_INV;
    endcase
  end

  assign sample       = (dwell_q == DW'(SCAN_DIV-1));
  assign frame_end    = sample && (col_q == CW'(COLS-1));
  assign same_as_cand = (res_kind == cand_kind_q) &&
                        ((res_kind != RES_KEY) || (merged_code == cand_code_q));

  // State register process.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rows_meta_q   <= '0;
      rows_sync_q   <= '0;
      dwell_q       <= '0;
      col_q         <= '0;
      cols_q        <= COLS'(1);
      acc_cnt_q     <= '0;
      acc_code_q    <= '0;
      cand_kind_q   <= RES_NONE;
      cand_code_q   <= '0;
      cnt_q         <= '0;
      stable_kind_q <= RES_NONE;
      key_q         <= '0;
      key_valid_q   <= 1'b0;
      key_rel_q     <= 1'b0;
      key_down_q    <= 1'b0;
      multi_q       <= 1'b0;
    end else begin
      rows_meta_q   <= keyRows;
      rows_sync_q   <= rows_meta_q;
      dwell_q       <= dwell_d;
      col_q         <= col_d;
      cols_q        <= cols_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_code_q    <= acc_code_d;
      cand_kind_q   <= cand_kind_d;
      cand_code_q   <= cand_code_d;
      cnt_q         <= cnt_d;
      stable_kind_q <= stable_kind_d;
      key_q         <= key_d;
      key_valid_q   <= key_valid_d;
      key_rel_q     <= key_rel_d;
      key_down_q    <= key_down_d;
      multi_q       <= multi_d;
    end
  end

  // Next-state process: scan timing, frame accumulation, debounce, acceptance.
  always_comb begin
    dwell_d       = dwell_q + DW'(1);
    col_d         = col_q;
    cols_d        = cols_q;
    acc_cnt_d     = acc_cnt_q;
    acc_code_d    = acc_code_q;
    cand_kind_d   = cand_kind_q;
    cand_code_d   = cand_code_q;
    cnt_d         = cnt_q;
    stable_kind_d = stable_kind_q;
    key_d         = key_q;
    key_valid_d   = 1'b0;
    key_rel_d     = 1'b0;
    key_down_d    = key_down_q;
    multi_d       = multi_q;

    if (sample) begin
      dwell_d = '0;
      cols_d  = {cols_q[COLS-2:0], cols_q[COLS-1]};
      col_d   = (col_q == CW'(COLS-1)) ? '0 : col_q + CW'(1);
      acc_cnt_d  = merged_cnt;
      acc_code_d = merged_code;
    end

    if (frame_end) begin
      acc_cnt_d  = '0;
      acc_code_d = '0;
      multi_d    = (res_kind == RES_INV);
      if (res_kind == RES_INV) begin
        // Invalid frames never count toward acceptance, which freezes outputs.
        cand_kind_d = RES_INV;
        cnt_d       = '0;
      end else if (same_as_cand) begin
        if (cnt_q != NW'(DEBOUNCE)) cnt_d = cnt_q + NW'(1);
      end else begin
        cand_kind_d = res_kind;
        cand_code_d = merged_code;
        cnt_d       = NW'(1);
      end

      // cnt_d is zero for an INVALID candidate, so only NONE/KEY get here.
      if ((cnt_d == NW'(DEBOUNCE)) &&
          ((cand_kind_d != stable_kind_q) ||
           ((cand_kind_d == RES_KEY) && (cand_code_d != key_q)))) begin
        stable_kind_d = cand_kind_d;
        if (cand_kind_d == RES_KEY) begin
          key_d       = cand_code_d;
          key_down_d  = 1'b1;
          key_valid_d = 1'b1;
        end else begin
          key_down_d  = 1'b0;
          key_rel_d   = 1'b1;
        end
      end
    end
  end

  // Output process.
  always_comb begin
    keyCols  = cols_q;
    Key      = key_q;
    KeyValid = key_valid_q;
    KeyRel   = key_rel_q;
    KeyDown  = key_down_q;
    Multi    = multi_q;
  end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Testbench for keypad_scan_decoder. The configuration is ROWS=COLS=4,
// SCAN_DIV=4 and DEBOUNCE=3, so one frame is 16 cycles. A behavioural keypad
// closes the switches in press_mask (bit = row*4+col), so a row line is high
// while the column of a pressed switch is strobed. A per-frame vector table
// gives the switch pattern for each frame and the expected outputs after that
// frame ends. Hand-written sequences cover reset and a reset mid-debounce.
module tb_keypad_scan_decoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  keyRows;
  logic [3:0]  keyCols;
  logic [3:0]  Key;
  logic        KeyValid, KeyRel, KeyDown, Multi;
  logic [15:0] press_mask = 16'h0000;

  int checks = 0;
  int passed = 0;
  bit prev_v = 1'b0;
  bit prev_r = 1'b0;
  logic [3:0] cols_at4, cols_at16;

  keypad_scan_decoder #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)
  ) dut (
    .CLK(CLK), .RST(RST), .keyRows(keyRows), .keyCols(keyCols), .Key(Key),
    .KeyValid(KeyValid), .KeyRel(KeyRel), .KeyDown(KeyDown), .Multi(Multi)
  );

  // Clock
  always #5 CLK = ~CLK;

  // Keypad matrix model
  always_comb begin
    keyRows = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_mask[r*4+c] && keyCols[c]) keyRows[r] = 1'b1;
  end

  typedef struct {
    logic [15:0] mask;
    int v;
    int r;
    int key;
    int down;
    int multi;
  } vec_t;

  vec_t vecs[34];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Runs one 16-cycle frame, sampling #1 after each edge. It counts the event
  // pulses, checks pulse shape, and checks the column strobe against the
  // frame position.
  task automatic run_frame(output int nv, output int nr,
                           output int pulse_bad, output int cols_bad);
    nv = 0; nr = 0; pulse_bad = 0; cols_bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge CLK); #1;
      if (KeyValid) nv++;
      if (KeyRel) nr++;
      if ((KeyValid && KeyRel) || (KeyValid && prev_v) || (KeyRel && prev_r))
        pulse_bad = 1;
      prev_v = KeyValid;
      prev_r = KeyRel;
      if (keyCols != (4'b0001 << ((k/4)%4))) cols_bad = 1;
      if (k == 4)  cols_at4  = keyCols;
      if (k == 16) cols_at16 = keyCols;
    end
  endtask

  initial begin
    int nv, nr, pb, cb;

    // mask, KeyValid count, KeyRel count, Key, KeyDown, Multi (after frame)
    vecs[0]  = '{16'h0200, 0, 0, 0, 0, 0};  // clean press, code 9
    vecs[1]  = '{16'h0200, 0, 0, 0, 0, 0};
    vecs[2]  = '{16'h0200, 1, 0, 9, 1, 0};
    vecs[3]  = '{16'h0200, 0, 0, 9, 1, 0};  // held: no repeat
    vecs[4]  = '{16'h0020, 0, 0, 9, 1, 0};  // change to code 5
    vecs[5]  = '{16'h0020, 0, 0, 9, 1, 0};
    vecs[6]  = '{16'h0020, 1, 0, 5, 1, 0};
    vecs[7]  = '{16'h0000, 0, 0, 5, 1, 0};  // release
    vecs[8]  = '{16'h0000, 0, 0, 5, 1, 0};
    vecs[9]  = '{16'h0000, 0, 1, 5, 0, 0};
    vecs[10] = '{16'h0000, 0, 0, 5, 0, 0};
    vecs[11] = '{16'h0200, 0, 0, 5, 0, 0};  // bounce on code 9
    vecs[12] = '{16'h0000, 0, 0, 5, 0, 0};
    vecs[13] = '{16'h0200, 0, 0, 5, 0, 0};
    vecs[14] = '{16'h0000, 0, 0, 5, 0, 0};
    vecs[15] = '{16'h0200, 0, 0, 5, 0, 0};
    vecs[16] = '{16'h0200, 0, 0, 5, 0, 0};
    vecs[17] = '{16'h0200, 1, 0, 9, 1, 0};
    vecs[18] = '{16'h0005, 0, 0, 9, 1, 1};  // row0 on col0 and col2
    vecs[19] = '{16'h0005, 0, 0, 9, 1, 1};
    vecs[20] = '{16'h0001, 0, 0, 9, 1, 0};  // drop col2
    vecs[21] = '{16'h0001, 0, 0, 9, 1, 0};
    vecs[22] = '{16'h0001, 1, 0, 0, 1, 0};
    vecs[23] = '{16'h0000, 0, 0, 0, 1, 0};
    vecs[24] = '{16'h0000, 0, 0, 0, 1, 0};
    vecs[25] = '{16'h0000, 0, 1, 0, 0, 0};
    vecs[26] = '{16'h0022, 0, 0, 0, 0, 1};  // two rows in one column
    vecs[27] = '{16'h0000, 0, 0, 0, 0, 0};
    vecs[28] = '{16'h8000, 0, 0, 0, 0, 0};  // highest code, last column
    vecs[29] = '{16'h8000, 0, 0, 0, 0, 0};
    vecs[30] = '{16'h8000, 1, 0, 15, 1, 0};
    vecs[31] = '{16'h0000, 0, 0, 15, 1, 0};
    vecs[32] = '{16'h0000, 0, 0, 15, 1, 0};
    vecs[33] = '{16'h0000, 0, 1, 15, 0, 0};

    // Reset: 3 cycles high
    RST = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      check("rst_cols", int'(keyCols), 1);
      check("rst_outs", int'({Key, KeyValid, KeyRel, KeyDown, Multi}), 0);
    end
    press_mask = vecs[0].mask;
    RST = 1'b0;

    // Table-driven frames
    for (int i = 0; i < 34; i++) begin
      press_mask = vecs[i].mask;
      run_frame(nv, nr, pb, cb);
      if (i == 0) begin
        check("cols_after4", int'(cols_at4), 2);
        check("cols_wrap16", int'(cols_at16), 1);
      end
      check($sformatf("f%0d_valid", i), nv, vecs[i].v);
      check($sformatf("f%0d_rel", i), nr, vecs[i].r);
      check($sformatf("f%0d_key", i), int'(Key), vecs[i].key);
      check($sformatf("f%0d_down", i), int'(KeyDown), vecs[i].down);
      check($sformatf("f%0d_multi", i), int'(Multi), vecs[i].multi);
      check($sformatf("f%0d_pulse", i), pb, 0);
      check($sformatf("f%0d_cols", i), cb, 0);
    end

    // Reset mid-debounce: two frames of code 9 build up progress, then a
    // reset mid-dwell must discard it and clear Key (currently 15).
    press_mask = 16'h0200;
    repeat (2) begin
      run_frame(nv, nr, pb, cb);
      check("pre_rst_valid", nv, 0);
    end
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
      check("midrst_cols", int'(keyCols), 1);
      check("midrst_key", int'(Key), 0);
      check("midrst_flags", int'({KeyValid, KeyRel, KeyDown, Multi}), 0);
    end
    RST = 1'b0;
    prev_v = 1'b0;
    prev_r = 1'b0;
    for (int f = 0; f < 3; f++) begin
      run_frame(nv, nr, pb, cb);
      check($sformatf("postrst_f%0d_valid", f), nv, (f == 2) ? 1 : 0);
      check($sformatf("postrst_f%0d_cols", f), cb, 0);
    end
    check("postrst_key", int'(Key), 9);
    check("postrst_down", int'(KeyDown), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
